// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch over a request/response imem, with a credit-limited prefetch FIFO
// and redirect handling that flushes buffered words and drops stale in-flight responses.
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h00000000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] inflight, drop, count;
    logic [AW-1:0] wr, rd, tw, tr;
    logic [31:0]   inst_mem [FIFO_DEPTH];
    logic [31:0]   pc_mem   [FIFO_DEPTH];
    logic [31:0]   tag_mem  [FIFO_DEPTH];
    logic          req_fire, keep, pop;

    always_comb begin
        o_imem_req_valid = !i_rst && !i_redirect_valid && ({1'b0, inflight} + {1'b0, count} < DEPTH);
        o_imem_req_addr  = {fetch_pc[31:2], 2'b00};
        req_fire         = o_imem_req_valid && i_imem_req_ready;
        keep             = !i_rst && !i_redirect_valid && i_imem_rsp_valid && drop == '0;
        o_inst_valid     = count != '0;
        pop              = o_inst_valid && i_inst_ready && !i_redirect_valid;
        o_inst           = o_inst_valid ? inst_mem[rd] : 32'h0;
        o_inst_pc        = o_inst_valid ? pc_mem[rd] : 32'h0;
    end

    // Tag queue holds only live requests; dropped responses never touch it.
    always_ff @(posedge i_clk) begin
        if (req_fire) tag_mem[tw] <= fetch_pc;
        if (keep) begin
            inst_mem[wr] <= i_imem_rsp_data;
            pc_mem[wr]   <= tag_mem[tr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc <= RESET_ADDR & ~32'h3;
            inflight <= '0;
            drop     <= '0;
            count    <= '0;
            wr       <= '0;
            rd       <= '0;
            tw       <= '0;
            tr       <= '0;
        end else if (i_redirect_valid) begin
            fetch_pc <= i_redirect_pc & ~32'h3;
            inflight <= inflight - CW'(i_imem_rsp_valid);
            drop     <= inflight - CW'(i_imem_rsp_valid);
            count    <= '0;
            wr       <= '0;
            rd       <= '0;
            tw       <= '0;
            tr       <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
                tw       <= tw + AW'(1);
            end
            inflight <= inflight + CW'(req_fire) - CW'(i_imem_rsp_valid);
            if (i_imem_rsp_valid && drop != '0) drop <= drop - CW'(1);
            if (keep) begin
                wr <= wr + AW'(1);
                tr <= tr + AW'(1);
            end
            if (pop) rd <= rd + AW'(1);
            count <= count + CW'(keep) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk) assert (i_rst || !i_imem_rsp_valid || inflight != '0);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed tests of fetch_unit against a fixed-latency in-order imem model.
module tb_fetch_unit;
    logic        clk = 0, rst = 1;
    logic        req_valid, req_ready = 1;
    logic [31:0] req_addr;
    logic        rsp_valid = 0;
    logic [31:0] rsp_data = 0;
    logic        redirect = 0;
    logic [31:0] rpc = 0;
    logic        inst_valid, inst_ready = 0;
    logic [31:0] inst, inst_pc;

    int checks = 0, errors = 0;
    int cyc = 0, lat = 1, req_cnt = 0;

    typedef struct {logic [31:0] a; int due;} req_t;
    typedef struct {logic [31:0] inst; logic [31:0] pc;} out_t;
    req_t pend[$];
    out_t got[$];

    fetch_unit dut (
        .i_clk(clk), .i_rst(rst),
        .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready), .o_imem_req_addr(req_addr),
        .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
        .i_redirect_valid(redirect), .i_redirect_pc(rpc),
        .o_inst_valid(inst_valid), .i_inst_ready(inst_ready), .o_inst(inst), .o_inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
            req_cnt = 0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
        end else begin
            if (req_valid && req_ready) begin
                pend.push_back('{req_addr, cyc + lat});
                req_cnt++;
            end
            if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
                rsp_valid <= 1'b1;
                rsp_data  <= word(pend[0].a);
                void'(pend.pop_front());
            end else begin
                rsp_valid <= 1'b0;
            end
        end
        cyc++;
    end

    always @(posedge clk)
        if (!rst && inst_valid && inst_ready && !redirect) got.push_back('{inst, inst_pc});

    task automatic do_reset(input int l, input logic rdy);
        @(negedge clk);
        rst = 1; redirect = 0; req_ready = 1; inst_ready = rdy; lat = l;
        repeat (3) @(negedge clk);
        got.delete();
        rst = 0;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
        checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h/%h want 0/0", inst, inst_pc); end
        checks++; if (req_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", req_addr); end
    endtask

    task automatic test_stream;
        do_reset(1, 1);
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin errors++; $display("FAIL stream_req0: got %b/%h want 1/0", req_valid, req_addr); end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid: got %b want 0", inst_valid); end
        checks++; if (req_addr !== 32'h4) begin errors++; $display("FAIL stream_req1: got %h want 4", req_addr); end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== word(0)) begin
            errors++; $display("FAIL stream_first: got %b/%h/%h want 1/0/%h", inst_valid, inst_pc, inst, word(0)); end
        repeat (8) @(negedge clk);
        checks++;
        if (got.size() < 3) begin errors++; $display("FAIL stream_count: got %0d want >=3", got.size()); end
        else for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i].pc !== 32'(4 * i) || got[i].inst !== word(32'(4 * i))) begin
                errors++; $display("FAIL stream_seq%0d: got %h/%h want %h/%h", i, got[i].pc, got[i].inst, 4 * i, word(32'(4 * i))); end
        end
    endtask

    task automatic test_stall;
        do_reset(1, 0);
        repeat (20) @(negedge clk);
        checks++; if (req_cnt !== 4) begin errors++; $display("FAIL stall_reqs: got %0d want 4", req_cnt); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid: got %b want 0", req_valid); end
        checks++; if (inst_valid !== 1'b1 || inst !== word(0) || inst_pc !== 32'h0) begin
            errors++; $display("FAIL stall_head: got %b/%h/%h want 1/%h/0", inst_valid, inst, inst_pc, word(0)); end
        inst_ready = 1;
        repeat (10) @(negedge clk);
        checks++;
        if (got.size() < 4) begin errors++; $display("FAIL stall_drain: got %0d want >=4", got.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i].pc !== 32'(4 * i)) begin errors++; $display("FAIL stall_seq%0d: got %h want %h", i, got[i].pc, 4 * i); end
        end
    endtask

    task automatic test_redirect_inflight;
        do_reset(3, 1);
        repeat (3) @(negedge clk);
        redirect = 1; rpc = 32'h100;
        #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL redir_req_blocked: got %b want 0", req_valid); end
        @(negedge clk);
        redirect = 0;
        #1;
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h100) begin errors++; $display("FAIL redir_req: got %b/%h want 1/100", req_valid, req_addr); end
        repeat (2) @(negedge clk);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_stale_valid: got %b want 0", inst_valid); end
        repeat (8) @(negedge clk);
        checks++;
        if (got.size() < 1) begin errors++; $display("FAIL redir_none: got 0 want >=1"); end
        else begin
            checks++; if (got[0].pc !== 32'h100 || got[0].inst !== word(32'h100)) begin
                errors++; $display("FAIL redir_first: got %h/%h want 100/%h", got[0].pc, got[0].inst, word(32'h100)); end
        end
    endtask

    task automatic test_redirect_collide;
        do_reset(2, 0);
        repeat (3) @(negedge clk);
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL coll_setup: got %b want 1", inst_valid); end
        inst_ready = 1; redirect = 1; rpc = 32'h300;
        @(negedge clk);
        redirect = 0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL coll_valid: got %b want 0", inst_valid); end
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h300) begin errors++; $display("FAIL coll_req: got %b/%h want 1/300", req_valid, req_addr); end
        repeat (10) @(negedge clk);
        checks++;
        if (got.size() < 2) begin errors++; $display("FAIL coll_none: got %0d want >=2", got.size()); end
        else begin
            checks++; if (got[0].pc !== 32'h300 || got[0].inst !== word(32'h300) || got[1].pc !== 32'h304) begin
                errors++; $display("FAIL coll_first: got %h/%h,%h want 300/%h,304", got[0].pc, got[0].inst, got[1].pc, word(32'h300)); end
        end
    endtask

    task automatic test_back_to_back;
        do_reset(2, 1);
        repeat (4) @(negedge clk);
        redirect = 1; rpc = 32'h202;
        @(negedge clk);
        redirect = 0;
        #1;
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h200) begin errors++; $display("FAIL align_addr: got %b/%h want 1/200", req_valid, req_addr); end
        repeat (6) @(negedge clk);
        got.delete();
        redirect = 1; rpc = 32'h40;
        @(negedge clk);
        rpc = 32'h80;
        @(negedge clk);
        redirect = 0;
        #1;
        checks++; if (req_addr !== 32'h80) begin errors++; $display("FAIL b2b_addr: got %h want 80", req_addr); end
        repeat (12) @(negedge clk);
        checks++;
        if (got.size() < 3) begin errors++; $display("FAIL b2b_count: got %0d want >=3", got.size()); end
        else for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i].pc !== 32'h80 + 32'(4 * i) || got[i].inst !== word(32'h80 + 32'(4 * i))) begin
                errors++; $display("FAIL b2b_seq%0d: got %h/%h want %h", i, got[i].pc, got[i].inst, 32'h80 + 32'(4 * i)); end
        end
    endtask

    task automatic test_reset_busy;
        do_reset(2, 0);
        repeat (4) @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || req_valid !== 1'b0) begin errors++; $display("FAIL rbusy_setup: got %b/%b want 1/0", inst_valid, req_valid); end
        rst = 1;
        @(negedge clk);
        checks++; if (req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || req_addr !== 32'h0) begin
            errors++; $display("FAIL rbusy_outputs: got %b/%b/%h/%h/%h want all 0", req_valid, inst_valid, inst, inst_pc, req_addr); end
        got.delete();
        rst = 0; inst_ready = 1;
        #1;
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin errors++; $display("FAIL rbusy_restart: got %b/%h want 1/0", req_valid, req_addr); end
        repeat (8) @(negedge clk);
        checks++;
        if (got.size() < 1) begin errors++; $display("FAIL rbusy_none: got 0 want >=1"); end
        else begin
            checks++; if (got[0].pc !== 32'h0 || got[0].inst !== word(0)) begin
                errors++; $display("FAIL rbusy_first: got %h/%h want 0/%h", got[0].pc, got[0].inst, word(0)); end
        end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_stall;
        test_redirect_inflight;
        test_redirect_collide;
        test_back_to_back;
        test_reset_busy;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
